// File: rtl/lab2_vector_seq.sv
// Stimulus/capture sequencer for the lab2 four-input function: sweeps {A,B,C,D}=0..15,
// samples E after a settle time, and reports the captured truth table. Option macro: LAB2_SEQ_FAIL_CAPTURE_EN.
`timescale 1ns/1ps
module lab2_vector_seq #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = 16'h0C1E
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_ack,
  input  logic        i_e_in,
  output logic        o_a,
  output logic        o_b,
  output logic        o_c,
  output logic        o_d,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_table,
  output logic        o_pass
`ifdef LAB2_SEQ_FAIL_CAPTURE_EN
  ,
  output logic [3:0]  o_fail_idx,
  output logic        o_fail_vld
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [7:0]  r_cnt;
  logic [15:0] r_table;
  logic        r_pass;
  logic        r_busy;
  logic        r_done;

  state_t      w_state_nxt;
  logic [3:0]  w_idx_nxt;
  logic [7:0]  w_cnt_nxt;
  logic [15:0] w_table_nxt;
  logic        w_pass_nxt;
  logic        w_sample;
  logic        w_clear;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 4'd0;
      r_cnt   <= 8'd0;
      r_table <= 16'h0000;
      r_pass  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_table <= w_table_nxt;
      r_pass  <= w_pass_nxt;
      r_busy  <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_table_nxt = r_table;
    w_pass_nxt  = r_pass;
    w_sample    = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_SETTLE;
          w_idx_nxt   = 4'd0;
          w_cnt_nxt   = 8'd0;
          w_table_nxt = 16'h0000;
          w_pass_nxt  = 1'b0;
          w_clear     = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = ST_SAMPLE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_SAMPLE: begin
        w_sample           = 1'b1;
        w_table_nxt[r_idx] = i_e_in;
        if (r_idx == 4'd15) begin
          // Bit 15 is still in flight this cycle, so fold it in from E_IN directly.
          w_state_nxt = ST_DONE;
          w_pass_nxt  = ({i_e_in, r_table[14:0]} == EXPECTED);
        end else begin
          w_idx_nxt   = r_idx + 4'd1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_DONE: begin
        if (i_ack) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = 4'd0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef LAB2_SEQ_FAIL_CAPTURE_EN
  logic [3:0] r_fail_idx;
  logic       r_fail_vld;

  // Only the first mismatch is latched; later ones leave it untouched.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fail_idx <= 4'd0;
      r_fail_vld <= 1'b0;
    end else if (w_clear) begin
      r_fail_idx <= 4'd0;
      r_fail_vld <= 1'b0;
    end else if (w_sample && !r_fail_vld && (i_e_in != EXPECTED[r_idx])) begin
      r_fail_idx <= r_idx;
      r_fail_vld <= 1'b1;
    end
  end

  assign o_fail_idx = r_fail_idx;
  assign o_fail_vld = r_fail_vld;
`else
  logic w_unused_sample;
  logic w_unused_clear;
  assign w_unused_sample = w_sample;
  assign w_unused_clear  = w_clear;
`endif

  assign o_a     = r_idx[3];
  assign o_b     = r_idx[2];
  assign o_c     = r_idx[1];
  assign o_d     = r_idx[0];
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_table = r_table;
  assign o_pass  = r_pass;

endmodule
